// File: rtl/video_timing_meas_if.sv
// Pin bundle between the sync-generator output tap and the timing monitor.
interface video_timing_meas_if #(
    parameter int unsigned CW = 16,
    parameter int unsigned SW = 8
);
    logic          meas_en;
    logic          hsync_i;
    logic          vsync_i;
    logic          de_i;
    logic          hpol_o;
    logic          vpol_o;
    logic [CW-1:0] htotal_o;
    logic [CW-1:0] hactive_o;
    logic [SW-1:0] hsw_o;
    logic [CW-1:0] vtotal_o;
    logic [CW-1:0] vactive_o;
    logic [SW-1:0] vsw_o;
    logic          meas_valid_o;
    logic          locked_o;
    logic          err_o;

    // Video source / bench side
    modport master (
        output meas_en, hsync_i, vsync_i, de_i,
        input  hpol_o, vpol_o, htotal_o, hactive_o, hsw_o,
        input  vtotal_o, vactive_o, vsw_o, meas_valid_o, locked_o, err_o
    );

    // Monitor side
    modport slave (
        input  meas_en, hsync_i, vsync_i, de_i,
        output hpol_o, vpol_o, htotal_o, hactive_o, hsw_o,
        output vtotal_o, vactive_o, vsw_o, meas_valid_o, locked_o, err_o
    );
endinterface

// File: rtl/video_timing_meas.sv
// Passive video timing monitor: detects sync polarity, measures per-frame
// horizontal/vertical timing and declares lock on two matching frames.
module video_timing_meas #(
    parameter int unsigned CW = 16,
    parameter int unsigned SW = 8
) (
    input  logic               clk,
    input  logic               rst,
    video_timing_meas_if.slave vif
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_POL  = 2'd1;
    localparam logic [1:0] S_SYNC = 2'd2;
    localparam logic [1:0] S_MEAS = 2'd3;

    localparam logic [CW-1:0] C_MAX = {CW{1'b1}};
    localparam logic [SW-1:0] S_MAX = {SW{1'b1}};

    logic [1:0]    state, state_nx;
    logic          hs_r, vs_r, de_r, hs_d, vs_d;
    logic          hpol_q, vpol_q;

    logic [CW-1:0] h_cnt, de_cnt, line_total, hact_ref, v_cnt, vact_cnt;
    logic [SW-1:0] hsw_cnt, hsw_line, vsw_cnt;
    logic          hact_seen, frame_err, prev_ok, close_d;

    logic [CW-1:0] htotal_q, hactive_q, vtotal_q, vactive_q;
    logic [SW-1:0] hsw_q, vsw_q;
    logic          meas_valid_q, locked_q, err_q;

    logic          hs_act, vs_act, hs_rise, vs_rise, run;
    logic          line_nz, line_bad, sat_hit, ferr_fin, match, lock_nx;
    logic [CW-1:0] htot_fin, href_fin, v_fin, vact_fin;
    logic [SW-1:0] hsw_fin, vsw_fin;

    function automatic logic [CW-1:0] inc_c(input logic [CW-1:0] x);
        return (x == C_MAX) ? x : x + CW'(1);
    endfunction

    function automatic logic [SW-1:0] inc_s(input logic [SW-1:0] x);
        return (x == S_MAX) ? x : x + SW'(1);
    endfunction

    // Sync levels normalised to "asserted" using the latched polarity
    assign hs_act  = hs_r ^ ~hpol_q;
    assign vs_act  = vs_r ^ ~vpol_q;
    assign hs_rise = hs_act & ~(hs_d ^ ~hpol_q);
    assign vs_rise = vs_act & ~(vs_d ^ ~vpol_q);
    assign run     = vif.meas_en & (state == S_MEAS);

    // Frame values including a line close on this cycle, lock decision
    always_comb begin
        line_nz  = run & hs_rise & (de_cnt != '0);
        line_bad = line_nz & hact_seen & (de_cnt != hact_ref);
        sat_hit  = run & ((~hs_rise & (h_cnt == C_MAX))
                        | (hs_act & ~hs_rise & (hsw_cnt == S_MAX))
                        | (de_r & ~hs_rise & (de_cnt == C_MAX))
                        | (hs_rise & (v_cnt == C_MAX))
                        | (hs_rise & vs_act & (vsw_cnt == S_MAX))
                        | (line_nz & (vact_cnt == C_MAX)));
        htot_fin = hs_rise ? h_cnt : line_total;
        hsw_fin  = hs_rise ? hsw_cnt : hsw_line;
        href_fin = (line_nz & ~hact_seen) ? de_cnt : hact_ref;
        v_fin    = hs_rise ? inc_c(v_cnt) : v_cnt;
        vsw_fin  = (hs_rise & vs_act) ? inc_s(vsw_cnt) : vsw_cnt;
        vact_fin = line_nz ? inc_c(vact_cnt) : vact_cnt;
        ferr_fin = frame_err | line_bad | sat_hit;
        match    = (htot_fin == htotal_q) && (href_fin == hactive_q)
                && (hsw_fin == hsw_q) && (v_fin == vtotal_q)
                && (vact_fin == vactive_q) && (vsw_fin == vsw_q);
        lock_nx  = prev_ok & ~ferr_fin & match;
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    // FSM next state
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: if (vif.meas_en) state_nx = S_POL;
            S_POL:  if (de_r)        state_nx = S_SYNC;
            S_SYNC: if (vs_rise)     state_nx = S_MEAS;
            S_MEAS: state_nx = S_MEAS;
            default: state_nx = S_IDLE;
        endcase
        if (!vif.meas_en) state_nx = S_IDLE;
    end

    // Input staging, counters and result registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hs_r <= 1'b0; vs_r <= 1'b0; de_r <= 1'b0; hs_d <= 1'b0; vs_d <= 1'b0;
            hpol_q <= 1'b0; vpol_q <= 1'b0;
            h_cnt <= '0; de_cnt <= '0; line_total <= '0; hact_ref <= '0;
            v_cnt <= '0; vact_cnt <= '0; hsw_cnt <= '0; hsw_line <= '0; vsw_cnt <= '0;
            hact_seen <= 1'b0; frame_err <= 1'b0; prev_ok <= 1'b0; close_d <= 1'b0;
            htotal_q <= '0; hactive_q <= '0; vtotal_q <= '0; vactive_q <= '0;
            hsw_q <= '0; vsw_q <= '0;
            meas_valid_q <= 1'b0; locked_q <= 1'b0; err_q <= 1'b0;
        end else begin
            hs_r <= vif.hsync_i;
            vs_r <= vif.vsync_i;
            de_r <= vif.de_i;
            hs_d <= hs_r;
            vs_d <= vs_r;
            close_d      <= 1'b0;
            meas_valid_q <= close_d;
            if (!vif.meas_en || state == S_IDLE) begin
                h_cnt <= '0; de_cnt <= '0; line_total <= '0; hact_ref <= '0;
                v_cnt <= '0; vact_cnt <= '0; hsw_cnt <= '0; hsw_line <= '0; vsw_cnt <= '0;
                hact_seen <= 1'b0; frame_err <= 1'b0; prev_ok <= 1'b0;
                locked_q <= 1'b0; err_q <= 1'b0;
            end else begin
                case (state)
                    S_POL: begin
                        // Sync level during active video is the inactive level
                        if (de_r) begin
                            hpol_q <= ~hs_r;
                            vpol_q <= ~vs_r;
                        end
                    end
                    S_SYNC: begin
                        if (vs_rise) begin
                            h_cnt <= CW'(hs_rise); hsw_cnt <= SW'(hs_act); de_cnt <= '0;
                            line_total <= '0; hsw_line <= '0; hact_ref <= '0;
                            v_cnt <= '0; vact_cnt <= '0; vsw_cnt <= '0;
                            hact_seen <= 1'b0; frame_err <= 1'b0;
                        end
                    end
                    S_MEAS: begin
                        h_cnt   <= hs_rise ? CW'(1) : inc_c(h_cnt);
                        hsw_cnt <= hs_rise ? SW'(1) : (hs_act ? inc_s(hsw_cnt) : hsw_cnt);
                        de_cnt  <= hs_rise ? CW'(de_r) : (de_r ? inc_c(de_cnt) : de_cnt);
                        if (hs_rise) begin
                            line_total <= h_cnt;
                            hsw_line   <= hsw_cnt;
                        end
                        if (line_bad || sat_hit) err_q <= 1'b1;
                        if (vs_rise) begin
                            htotal_q  <= htot_fin;
                            hactive_q <= href_fin;
                            hsw_q     <= hsw_fin;
                            vtotal_q  <= v_fin;
                            vactive_q <= vact_fin;
                            vsw_q     <= vsw_fin;
                            locked_q  <= lock_nx;
                            prev_ok   <= ~ferr_fin;
                            close_d   <= 1'b1;
                            v_cnt <= '0; vsw_cnt <= '0; vact_cnt <= '0;
                            hact_ref <= '0; hact_seen <= 1'b0; frame_err <= 1'b0;
                        end else begin
                            v_cnt     <= v_fin;
                            vsw_cnt   <= vsw_fin;
                            vact_cnt  <= vact_fin;
                            hact_ref  <= href_fin;
                            hact_seen <= hact_seen | line_nz;
                            frame_err <= ferr_fin;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign vif.hpol_o       = hpol_q;
    assign vif.vpol_o       = vpol_q;
    assign vif.htotal_o     = htotal_q;
    assign vif.hactive_o    = hactive_q;
    assign vif.hsw_o        = hsw_q;
    assign vif.vtotal_o     = vtotal_q;
    assign vif.vactive_o    = vactive_q;
    assign vif.vsw_o        = vsw_q;
    assign vif.meas_valid_o = meas_valid_q;
    assign vif.locked_o     = locked_q;
    assign vif.err_o        = err_q;

endmodule

// File: tb/tb_video_timing_meas.sv
// Bench for video_timing_meas: a scaled-down video timing generator drives the
// monitor; expected frame reports are queued and checked on meas_valid_o.
module tb_video_timing_meas;

    localparam int unsigned CW = 10;
    localparam int unsigned SW = 8;
    // Line: hsync, back porch, active, front porch. Frame: same order in lines.
    localparam int HA = 16, HFP = 2, HSW = 3, HBP = 3;
    localparam int VA = 8,  VFP = 2, VSW = 2, VBP = 2;
    localparam int VT = VSW + VBP + VA + VFP;

    typedef struct {
        logic hpol; logic vpol;
        int htotal; int hactive; int hsw;
        int vtotal; int vactive; int vsw;
        logic locked; logic err;
    } exp_t;

    logic clk = 1'b0;
    logic rst;

    video_timing_meas_if #(.CW(CW), .SW(SW)) vif ();

    video_timing_meas #(.CW(CW), .SW(SW)) dut (
        .clk (clk),
        .rst (rst),
        .vif (vif)
    );

    always #5 clk = ~clk;

    exp_t q[$];
    int   n_vec = 0;
    int   n_mis = 0;
    int   cyc = 0;
    int   vs_cyc = 0;
    bit   hp = 1'b0;
    bit   vp = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_mis++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    function automatic exp_t mk(input logic h, input logic v, input int ht, input int ha,
                                input int hs, input int vt, input int va, input int vs,
                                input logic lk, input logic er);
        exp_t e;
        e.hpol = h; e.vpol = v; e.htotal = ht; e.hactive = ha; e.hsw = hs;
        e.vtotal = vt; e.vactive = va; e.vsw = vs; e.locked = lk; e.err = er;
        return e;
    endfunction

    task automatic chk_zero(input string tag);
        chk({tag, "_hpol"},    32'(vif.hpol_o), 0);
        chk({tag, "_vpol"},    32'(vif.vpol_o), 0);
        chk({tag, "_htotal"},  32'(vif.htotal_o), 0);
        chk({tag, "_hactive"}, 32'(vif.hactive_o), 0);
        chk({tag, "_hsw"},     32'(vif.hsw_o), 0);
        chk({tag, "_vtotal"},  32'(vif.vtotal_o), 0);
        chk({tag, "_vactive"}, 32'(vif.vactive_o), 0);
        chk({tag, "_vsw"},     32'(vif.vsw_o), 0);
        chk({tag, "_valid"},   32'(vif.meas_valid_o), 0);
        chk({tag, "_locked"},  32'(vif.locked_o), 0);
        chk({tag, "_err"},     32'(vif.err_o), 0);
    endtask

    // One pixel clock of stimulus, given asserted/deasserted sync intent
    task automatic drive(input bit hs_a, input bit vs_a, input bit de, input bit mark);
        @(posedge clk);
        #1;
        vif.hsync_i = hp ? hs_a : ~hs_a;
        vif.vsync_i = vp ? vs_a : ~vs_a;
        vif.de_i    = de;
        if (mark) vs_cyc = cyc;
    endtask

    task automatic run_frame(input int hbp, input int bad_line, input int rst_line);
        int  ht;
        int  na;
        bit  act_line;
        bit  de;
        ht = HSW + hbp + HA + HFP;
        for (int l = 0; l < VT; l++) begin
            act_line = (l >= VSW + VBP) && (l < VSW + VBP + VA);
            na = (l == bad_line) ? HA - 1 : HA;
            for (int p = 0; p < ht; p++) begin
                de = act_line && (p >= HSW + hbp) && (p < HSW + hbp + na);
                drive(p < HSW, l < VSW, de, (l == 0) && (p == 0));
                if (l == rst_line && p == 0) begin
                    rst = 1'b1;
                    #2;
                    chk_zero("mid_reset");
                end else begin
                    rst = 1'b0;
                end
            end
        end
    endtask

    // Frame of 4-clock lines with no active video, long enough to saturate vtotal
    task automatic run_long(input int nl);
        for (int l = 0; l < nl; l++)
            for (int p = 0; p < 4; p++)
                drive(p == 0, l < VSW, 1'b0, (l == 0) && (p == 0));
    endtask

    task automatic start(input bit h, input bit v);
        hp = h;
        vp = v;
        repeat (3) drive(1'b0, 1'b0, 1'b0, 1'b0);
        vif.meas_en = 1'b1;
    endtask

    task automatic stop();
        vif.meas_en = 1'b0;
        repeat (3) drive(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (rst === 1'b0 && vif.meas_valid_o === 1'b1) begin
            if (q.size() == 0) begin
                n_vec++;
                n_mis++;
                $display("FAIL stray_meas_valid: pulse at cycle %0d, expected no report", cyc);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("valid_latency", 32'(cyc - vs_cyc), 3);
                chk("hpol",    32'(vif.hpol_o),    32'(e.hpol));
                chk("vpol",    32'(vif.vpol_o),    32'(e.vpol));
                chk("htotal",  32'(vif.htotal_o),  32'(e.htotal));
                chk("hactive", 32'(vif.hactive_o), 32'(e.hactive));
                chk("hsw",     32'(vif.hsw_o),     32'(e.hsw));
                chk("vtotal",  32'(vif.vtotal_o),  32'(e.vtotal));
                chk("vactive", 32'(vif.vactive_o), 32'(e.vactive));
                chk("vsw",     32'(vif.vsw_o),     32'(e.vsw));
                chk("locked",  32'(vif.locked_o),  32'(e.locked));
                chk("err",     32'(vif.err_o),     32'(e.err));
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        vif.meas_en = 1'b0;
        vif.hsync_i = 1'b1;
        vif.vsync_i = 1'b1;
        vif.de_i    = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_zero("reset");
        @(posedge clk);
        #1 rst = 1'b0;

        // Active-low syncs: lock at the second report
        start(1'b0, 1'b0);
        run_frame(HBP, -1, -1);
        q.push_back(mk(0, 0, 24, 16, 3, 14, 8, 2, 0, 0));
        run_frame(HBP, -1, -1);
        q.push_back(mk(0, 0, 24, 16, 3, 14, 8, 2, 1, 0));
        run_frame(HBP, -1, -1);
        run_frame(HBP, -1, -1);
        stop();
        chk("idle_hold_htotal", 32'(vif.htotal_o), 24);

        // Active-high syncs, back porch grows by one from frame 3
        start(1'b1, 1'b1);
        run_frame(HBP, -1, -1);
        q.push_back(mk(1, 1, 24, 16, 3, 14, 8, 2, 0, 0));
        run_frame(HBP, -1, -1);
        q.push_back(mk(1, 1, 24, 16, 3, 14, 8, 2, 1, 0));
        run_frame(HBP, -1, -1);
        q.push_back(mk(1, 1, 25, 16, 3, 14, 8, 2, 0, 0));
        run_frame(HBP + 1, -1, -1);
        q.push_back(mk(1, 1, 25, 16, 3, 14, 8, 2, 1, 0));
        run_frame(HBP + 1, -1, -1);
        run_frame(HBP + 1, -1, -1);
        stop();

        // One short active line in frame 2: sticky error until meas_en drops
        start(1'b0, 1'b0);
        run_frame(HBP, -1, -1);
        q.push_back(mk(0, 0, 24, 16, 3, 14, 8, 2, 0, 0));
        run_frame(HBP, -1, -1);
        q.push_back(mk(0, 0, 24, 16, 3, 14, 8, 2, 0, 1));
        run_frame(HBP, 6, -1);
        q.push_back(mk(0, 0, 24, 16, 3, 14, 8, 2, 0, 1));
        run_frame(HBP, -1, -1);
        run_frame(HBP, -1, -1);
        chk("err_sticky", 32'(vif.err_o), 1);
        stop();
        chk("err_cleared", 32'(vif.err_o), 0);
        chk("lock_cleared", 32'(vif.locked_o), 0);

        // Vertical total saturates at all-ones
        start(1'b0, 1'b0);
        run_frame(HBP, -1, -1);
        q.push_back(mk(0, 0, 4, 0, 1, 1023, 0, 2, 0, 1));
        run_long(1100);
        run_frame(HBP, -1, -1);
        stop();

        // Reset in the middle of frame 3: re-acquire before reporting again
        start(1'b0, 1'b0);
        run_frame(HBP, -1, -1);
        q.push_back(mk(0, 0, 24, 16, 3, 14, 8, 2, 0, 0));
        run_frame(HBP, -1, -1);
        q.push_back(mk(0, 0, 24, 16, 3, 14, 8, 2, 1, 0));
        run_frame(HBP, -1, -1);
        run_frame(HBP, -1, 5);
        q.push_back(mk(0, 0, 24, 16, 3, 14, 8, 2, 0, 0));
        run_frame(HBP, -1, -1);
        q.push_back(mk(0, 0, 24, 16, 3, 14, 8, 2, 1, 0));
        run_frame(HBP, -1, -1);
        run_frame(HBP, -1, -1);
        stop();

        chk("reports_outstanding", 32'(q.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule

// File: doc/video_timing_meas.md
Name: video_timing_meas

Overview:
- Downstream monitor of the output sync generator; samples its hsync/vsync/de on the same pixel clock.
- Detects sync polarity and measures per-frame horizontal and vertical timing.
- Declares lock after two consecutive identical frames.
- Results feed the status registers and the bring-up bench; the block never alters the video path.

Parameters:
CW, 16, width of the active/total counters and outputs
SW, 8, width of the sync-width counters and outputs

Ports:
clk  in  1  pixel clock
rst  in  1  asynchronous active-high reset
meas_en  in  1  measurement enable; 0 forces IDLE
hsync_i  in  1  horizontal sync, either polarity
vsync_i  in  1  vertical sync, either polarity
de_i  in  1  data enable, active high
hpol_o  out  1  1 = hsync active-high
vpol_o  out  1  1 = vsync active-high
htotal_o  out  CW  clocks per line
hactive_o  out  CW  de-high clocks per active line
hsw_o  out  SW  hsync asserted clocks
vtotal_o  out  CW  lines per frame
vactive_o  out  CW  lines containing de
vsw_o  out  SW  lines with vsync asserted
meas_valid_o  out  1  one-cycle pulse when the outputs update
locked_o  out  1  two consecutive frames match
err_o  out  1  sticky: saturation or intra-frame hactive mismatch; cleared on IDLE

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous and active-high. On reset all outputs are 0 and the FSM enters IDLE.
- Input registering: the inputs pass through one register stage, plus a delayed copy for edge detection. All edges below refer to the registered signals.
- Polarity:
  - On the first registered de=1 cycle, hpol_o <= ~hsync and vpol_o <= ~vsync.
  - The inactive level is the level seen during active video.
  - hs_act = hsync ^ ~hpol_o; vs_act is derived the same way from vsync and vpol_o.
- FSM states:
  - IDLE: if meas_en=1, go to POL.
  - POL: on de=1, latch polarity and go to SYNC.
  - SYNC: on the vs_act rising edge, clear all counters and go to MEAS.
  - MEAS: measurement runs here.
  - meas_en=0 in any state returns to IDLE. IDLE clears locked_o, err_o and the counters; the measurement outputs hold their values.
- Horizontal measurement, in MEAS:
  - h_cnt increments every clock and restarts at 1 on the cycle after an hs_act rising edge.
  - The h_cnt value at that edge is captured as line total.
  - hsw_cnt counts hs_act=1 clocks.
  - de_cnt counts de=1 clocks; de_cnt and hsw_cnt are cleared on each hs_act rising edge.
- Line close: at each hs_act rising edge, if de_cnt != 0:
  - vactive_cnt increments;
  - if a previous non-zero line in the frame had a different de_cnt, the frame-error flag is set.
- Vertical measurement:
  - v_cnt counts hs_act rising edges.
  - vsw_cnt counts hs_act rising edges that occur while vs_act=1.
- Frame close: on a vs_act rising edge in MEAS, the frame's values load into the outputs.
  - Output update is registered; meas_valid_o pulses on the following cycle.
  - Total latency is 3 clk from the raw vsync edge at the pins.
  - Same cycle: the frame counters clear, then restart.
- Lock:
  - locked_o=1 when the just-closed frame's six values equal the previous frame's and neither frame had an error.
  - Any mismatch or error drops locked_o on the same update.
- Saturation: counters saturate at all-ones (CW or SW). Saturation sets err_o, and that frame cannot lock.
- Simultaneous edges: when hs_act and vs_act rise on the same cycle, the line close is processed before the frame close, and the line counts into the closing frame.
- Reset mid-frame: reset aborts immediately. After reset the FSM needs POL and SYNC again; no partial frame is ever reported.
- de outside MEAS: ignored, except the first de=1 in POL.

Test Plan:
- Stimulus: hpol active-low, hactive 720, hfp 20, hsw 10, hbp 20, vactive 480, vfp 20, vsw 10, vbp 20. Required: after frame 2, hpol_o=0, vpol_o=0, htotal_o=770, hactive_o=720, hsw_o=10, vtotal_o=530, vactive_o=480, vsw_o=10.
  - meas_valid_o pulses once per frame.
  - locked_o rises at the second meas_valid_o; err_o=0.
- Same timing with both syncs active-high. Required: hpol_o=1, vpol_o=1, identical counts, lock after two frames.
- Change hbp to 21 in frame 3. Required: htotal_o=771, locked_o=0 at the frame-3 update, locked_o=1 again at the frame-4 update.
- One line with 719 de cycles. Required: err_o=1, locked_o=0; err_o clears only after meas_en is toggled low.
- Hold vsync inactive for more than 2^16 lines of 4 clocks. Required: vtotal_o=16'hFFFF, err_o=1.
- Assert rst for 1 cycle mid-frame 3. Required: all outputs 0 immediately, and the next meas_valid_o only after polarity detection plus two vsync edges.
